// File: rtl/acia_tx_fifo.sv
// acia_tx_fifo
// 6551-style ACIA transmitter with an integrated transmit FIFO. Everything
// runs on BCLK (16x baud). Words of 5..8 bits are framed with an optional
// odd/even/mark/space parity bit and 1, 1.5 or 2 stop bits. Also handles
// CTS flow control and break generation.
//
// Ports:
//   BCLK, RESET         16x baud clock; asynchronous active-low reset
//   WR_DATA, WR_EN      enqueue port (one word per cycle)
//   FULL, EMPTY, LEVEL  registered FIFO status
//   DROP                one-cycle pulse after a write rejected while FULL
//   R_WL, R_PME, R_PMC  word length, parity enable, parity mode
//   R_SBN               stop-bit select
//   BREAK, CTSB         break request; clear-to-send (active low)
//   TX, BUSY            registered serial output; frame/break in progress
module acia_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             BCLK,
    input  logic             RESET,
    input  logic [7:0]       WR_DATA,
    input  logic             WR_EN,
    output logic             FULL,
    output logic             EMPTY,
    output logic [LVL_W-1:0] LEVEL,
    output logic             DROP,
    input  logic [1:0]       R_WL,
    input  logic             R_PME,
    input  logic [1:0]       R_PMC,
    input  logic             R_SBN,
    input  logic             BREAK,
    input  logic             CTSB,
    output logic             TX,
    output logic             BUSY
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK, S_BRKEND
    } state_t;

    // Last tick index of the stop period (S-1).
    function automatic logic [4:0] stop_last(input logic sbn, input logic [1:0] wl,
                                             input logic pme);
        logic [4:0] v;
        if (!sbn)
            v = 5'd15;
        else if (wl == 2'b11 && !pme)
            v = 5'd23;
        else if (wl == 2'b00 && pme)
            v = 5'd15;
        else
            v = 5'd31;
        return v;
    endfunction

    function automatic logic parity_bit(input logic [1:0] pmc, input logic par);
        logic b;
        case (pmc)
            2'b00:   b = ~par;
            2'b01:   b = par;
            2'b10:   b = 1'b1;
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] count, count_d;
    logic             push, load;

    state_t           state, state_d;
    logic [4:0]       tick, tick_d;
    logic [2:0]       bitn, bitn_d;
    logic [7:0]       shift, shift_d;
    logic             par, par_d;
    logic [1:0]       wl_q, wl_d, pmc_q, pmc_d;
    logic             pme_q, pme_d, sbn_q, sbn_d;
    logic             tx_d, load_ok;
    logic [2:0]       wl_last;

    assign push    = WR_EN && !FULL;
    assign load_ok = !EMPTY && !CTSB && !BREAK;
    assign wl_last = 3'd7 - {1'b0, wl_q};
    assign LEVEL   = count;

    always_comb begin
        count_d = count;
        if (push && !load)
            count_d = count + LVL_W'(1);
        else if (!push && load)
            count_d = count - LVL_W'(1);
    end

    // Next-state, shift/parity and frame-setting update.
    always_comb begin
        state_d = state;
        tick_d  = tick + 5'd1;
        bitn_d  = bitn;
        shift_d = shift;
        par_d   = par;
        wl_d    = wl_q;
        pmc_d   = pmc_q;
        pme_d   = pme_q;
        sbn_d   = sbn_q;
        load    = 1'b0;

        case (state)
            S_IDLE: begin
                tick_d = 5'd0;
                if (load_ok)
                    load = 1'b1;
                else if (BREAK)
                    state_d = S_BRK;
            end
            S_START: begin
                if (tick == 5'd15) begin
                    state_d = S_DATA;
                    tick_d  = 5'd0;
                end
            end
            S_DATA: begin
                if (tick == 5'd15) begin
                    tick_d  = 5'd0;
                    par_d   = par ^ shift[0];
                    shift_d = {1'b0, shift[7:1]};
                    if (bitn == wl_last)
                        state_d = pme_q ? S_PARITY : S_STOP;
                    else
                        bitn_d = bitn + 3'd1;
                end
            end
            S_PARITY: begin
                if (tick == 5'd15) begin
                    state_d = S_STOP;
                    tick_d  = 5'd0;
                end
            end
            S_STOP: begin
                // Last stop tick is the only mid-frame point where CTSB and
                // BREAK are looked at, so frames are never truncated.
                if (tick == stop_last(sbn_q, wl_q, pme_q)) begin
                    tick_d = 5'd0;
                    if (load_ok)
                        load = 1'b1;
                    else if (BREAK)
                        state_d = S_BRK;
                    else
                        state_d = S_IDLE;
                end
            end
            S_BRK: begin
                tick_d = 5'd0;
                if (!BREAK)
                    state_d = S_BRKEND;
            end
            S_BRKEND: begin
                if (tick == 5'd15) begin
                    state_d = S_IDLE;
                    tick_d  = 5'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame load: pop the head and latch the frame format for this word.
        if (load) begin
            state_d = S_START;
            tick_d  = 5'd0;
            bitn_d  = 3'd0;
            shift_d = mem[rd_ptr];
            par_d   = 1'b0;
            wl_d    = R_WL;
            pmc_d   = R_PMC;
            pme_d   = R_PME;
            sbn_d   = R_SBN;
        end

        // TX is registered from the next state so the pin never glitches.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_bit(pmc_d, par_d);
            S_BRK:    tx_d = 1'b0;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge BCLK or negedge RESET) begin
        if (!RESET) begin
            state  <= S_IDLE;
            tick   <= 5'd0;
            bitn   <= 3'd0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            FULL   <= 1'b0;
            EMPTY  <= 1'b1;
            DROP   <= 1'b0;
            TX     <= 1'b1;
            BUSY   <= 1'b0;
        end else begin
            state  <= state_d;
            tick   <= tick_d;
            bitn   <= bitn_d;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (load)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count  <= count_d;
            FULL   <= (count_d == LVL_W'(DEPTH));
            EMPTY  <= (count_d == '0);
            DROP   <= WR_EN && FULL;
            TX     <= tx_d;
            BUSY   <= (state_d != S_IDLE);
        end
    end

    always_ff @(posedge BCLK) begin
        if (push)
            mem[wr_ptr] <= WR_DATA;
        shift <= shift_d;
        par   <= par_d;
        wl_q  <= wl_d;
        pmc_q <= pmc_d;
        pme_q <= pme_d;
        sbn_q <= sbn_d;
    end

endmodule

// File: tb/tb_acia_tx_fifo.sv
// tb_acia_tx_fifo
// Randomised and directed stimulus for acia_tx_fifo. A reference model keeps
// the FIFO as a queue and each transmitted frame as a per-cycle queue of
// expected TX levels, built from the framing rules when a word is loaded.
module tb_acia_tx_fifo;
    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             BCLK    = 1'b0;
    logic             RESET   = 1'b0;
    logic [7:0]       WR_DATA = 8'h00;
    logic             WR_EN   = 1'b0;
    logic             FULL, EMPTY, DROP, TX, BUSY;
    logic [LVL_W-1:0] LEVEL;
    logic [1:0]       R_WL    = 2'b00;
    logic             R_PME   = 1'b0;
    logic [1:0]       R_PMC   = 2'b00;
    logic             R_SBN   = 1'b0;
    logic             BREAK   = 1'b0;
    logic             CTSB    = 1'b0;

    acia_tx_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .BCLK(BCLK), .RESET(RESET), .WR_DATA(WR_DATA), .WR_EN(WR_EN),
        .FULL(FULL), .EMPTY(EMPTY), .LEVEL(LEVEL), .DROP(DROP),
        .R_WL(R_WL), .R_PME(R_PME), .R_PMC(R_PMC), .R_SBN(R_SBN),
        .BREAK(BREAK), .CTSB(CTSB), .TX(TX), .BUSY(BUSY)
    );

    always #5 BCLK = ~BCLK;

    int total = 0;
    int bad   = 0;

    bit [7:0] fifo_m[$];
    bit       wave_m[$];
    bit       frame_m = 1'b0;
    bit       brk_m   = 1'b0;
    bit       drop_m  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fifo_m.delete();
        wave_m.delete();
        frame_m = 1'b0;
        brk_m   = 1'b0;
        drop_m  = 1'b0;
    endtask

    task automatic push_bits(input bit b, input int n);
        repeat (n) wave_m.push_back(b);
    endtask

    // Whole-frame waveform from the current format settings.
    task automatic build_frame(input bit [7:0] d);
        int wl;
        int s;
        bit p;
        bit pb;
        wl = 8 - int'(R_WL);
        p  = 1'b0;
        push_bits(1'b0, 16);
        for (int i = 0; i < wl; i++) begin
            p ^= d[i];
            push_bits(d[i], 16);
        end
        if (R_PME) begin
            case (R_PMC)
                2'b00:   pb = ~p;
                2'b01:   pb = p;
                2'b10:   pb = 1'b1;
                default: pb = 1'b0;
            endcase
            push_bits(pb, 16);
        end
        s = 16;
        if (R_SBN) begin
            if (wl == 5 && !R_PME)
                s = 24;
            else if (wl == 8 && R_PME)
                s = 16;
            else
                s = 32;
        end
        push_bits(1'b1, s);
    endtask

    // Advance the model by one rising edge using the inputs seen at it.
    task automatic model_step();
        bit decide;
        bit full_pre;
        bit nonempty_pre;
        decide       = 1'b0;
        full_pre     = (fifo_m.size() == DEPTH);
        nonempty_pre = (fifo_m.size() != 0);
        drop_m       = WR_EN && full_pre;
        if (brk_m) begin
            if (!BREAK) begin
                brk_m   = 1'b0;
                frame_m = 1'b0;
                push_bits(1'b1, 16);
            end
        end else if (wave_m.size() == 0) begin
            decide = 1'b1;
        end else begin
            void'(wave_m.pop_front());
            if (wave_m.size() == 0 && frame_m)
                decide = 1'b1;
        end
        if (decide) begin
            if (nonempty_pre && !CTSB && !BREAK) begin
                build_frame(fifo_m.pop_front());
                frame_m = 1'b1;
            end else if (BREAK) begin
                brk_m = 1'b1;
            end
        end
        if (WR_EN && !full_pre)
            fifo_m.push_back(WR_DATA);
    endtask

    task automatic compare_all();
        bit etx;
        bit ebusy;
        etx   = (wave_m.size() != 0) ? wave_m[0] : !brk_m;
        ebusy = (wave_m.size() != 0) || brk_m;
        check_eq("tx",    32'(TX),    32'(etx));
        check_eq("busy",  32'(BUSY),  32'(ebusy));
        check_eq("level", 32'(LEVEL), 32'(fifo_m.size()));
        check_eq("full",  32'(FULL),  32'(fifo_m.size() == DEPTH));
        check_eq("empty", 32'(EMPTY), 32'(fifo_m.size() == 0));
        check_eq("drop",  32'(DROP),  32'(drop_m));
    endtask

    task automatic cycle();
        @(posedge BCLK);
        if (RESET)
            model_step();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic write(input logic [7:0] d);
        WR_DATA = d;
        WR_EN   = 1'b1;
        cycle();
        WR_EN   = 1'b0;
    endtask

    task automatic set_fmt(input logic [1:0] wl, input logic pme, input logic [1:0] pmc,
                           input logic sbn);
        R_WL  = wl;
        R_PME = pme;
        R_PMC = pmc;
        R_SBN = sbn;
    endtask

    // Waits for BUSY to rise, then counts the cycles it stays high.
    task automatic busy_len(input string tag, input int exp);
        int n;
        int g;
        n = 0;
        g = 0;
        while (!BUSY && g < 10) begin
            cycle();
            g++;
        end
        while (BUSY && n < 2000) begin
            cycle();
            n++;
        end
        check_eq(tag, 32'(n), 32'(exp));
    endtask

    task automatic drain(input string tag, input int max);
        int g;
        g = 0;
        while ((BUSY || !EMPTY) && g < max) begin
            cycle();
            g++;
        end
        check_eq(tag, 32'(BUSY || !EMPTY), 32'd0);
    endtask

    initial begin
        model_reset();
        run(3);
        check_eq("rst_tx", 32'(TX), 32'd1);
        check_eq("rst_empty", 32'(EMPTY), 32'd1);
        RESET = 1'b1;
        run(2);

        // 8N1, 0x55
        set_fmt(2'b00, 1'b0, 2'b00, 1'b0);
        write(8'h55);
        check_eq("lvl_after_write", 32'(LEVEL), 32'd1);
        busy_len("8n1_busy", 160);
        run(3);

        // 7 data bits, even parity, two stop bits
        set_fmt(2'b01, 1'b1, 2'b01, 1'b1);
        write(8'hC3);
        busy_len("7e2_busy", 16 * (1 + 7 + 1) + 32);
        run(3);

        // 5N with 1.5 stop bits, back-to-back frames
        set_fmt(2'b11, 1'b0, 2'b00, 1'b1);
        write(8'h1F);
        write(8'h00);
        busy_len("5n_b2b_busy", 2 * (16 * 6 + 24));
        run(3);

        // Flow control hold-off and overflow
        set_fmt(2'b00, 1'b0, 2'b00, 1'b0);
        CTSB = 1'b1;
        for (int i = 0; i < 5; i++)
            write(8'(8'h30 + i));
        check_eq("cts_drop", 32'(DROP), 32'd1);
        check_eq("cts_full", 32'(FULL), 32'd1);
        check_eq("cts_level", 32'(LEVEL), 32'd4);
        run(20);
        check_eq("cts_tx_idle", 32'(TX), 32'd1);
        CTSB = 1'b0;
        drain("cts_drain", 4 * 160 + 50);
        run(3);

        // Break raised mid-frame with two words queued
        write(8'hA1);
        write(8'hB2);
        write(8'hC3);
        run(40);
        BREAK = 1'b1;
        run(250);
        check_eq("brk_tx", 32'(TX), 32'd0);
        check_eq("brk_level", 32'(LEVEL), 32'd2);
        BREAK = 1'b0;
        drain("brk_drain", 2 * 160 + 16 + 50);
        run(3);

        // Asynchronous reset during DATA
        write(8'h3C);
        run(40);
        #2;
        RESET = 1'b0;
        #1;
        model_reset();
        compare_all();
        run(2);
        RESET = 1'b1;
        write(8'hA5);
        busy_len("post_reset_busy", 160);
        run(3);

        // Randomised traffic, flow control, break and format changes
        for (int c = 0; c < 4000; c++) begin
            WR_EN   = ($urandom_range(0, 3) == 0);
            WR_DATA = 8'($urandom);
            if ($urandom_range(0, 99) == 0)
                CTSB = ~CTSB;
            if (BREAK) begin
                if ($urandom_range(0, 59) == 0)
                    BREAK = 1'b0;
            end else if ($urandom_range(0, 799) == 0) begin
                BREAK = 1'b1;
            end
            if ($urandom_range(0, 39) == 0)
                set_fmt(2'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
            cycle();
        end
        WR_EN = 1'b0;
        BREAK = 1'b0;
        CTSB  = 1'b0;
        drain("rand_drain", 20000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
